dif_fft_stream_ctrl: RTL and testbench
======================================

// Module: dif_fft_stream_ctrl
// PURPOSE
//  Streaming sequencer around the combinational 8-point dif_fft core.
//  - Collects 8 serial input samples into a ping buffer over a valid/ready input port.
//  - Presents the buffer to dif_fft.
//  - Captures xk0..xk7 into a pong buffer and streams X[0..7] out on a valid/ready output port.
//  - Loading of frame n+1 overlaps unloading of frame n, giving a sustained rate of 1 sample/clk.
// PARAMETERS
//  DW  32  sample width; {re[31:16], im[15:0]} two's complement; must match dif_fft
//  N   8   frame length; fixed by core, not overridable (localparam in defs include)
// PORTS
//  clk      in   1   single clock, rising edge
//  rst      in   1   synchronous, active-high reset
//  s_valid  in   1   input sample valid
//  s_ready  out  1   ctrl can accept sample
//  s_data   in   DW  input sample x[n], n = arrival order 0..7
//  s_last   in   1   source marks sample 7 of frame (checked only)
//  m_valid  out  1   output sample valid
//  m_ready  in   1   sink accepts output sample
//  m_data   out  DW  X[k], natural order k = 0..7
//  m_index  out  3   k of current m_data
//  m_last   out  1   high with k == 7
//  busy     out  1   any frame partially loaded, full, or unloading
//  err_frm  out  1   sticky: s_last misaligned with sample count
// BEHAVIOUR
//  Reset (rst=1 at edge) clears all state.
//  - Outputs after reset: s_ready=1, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, err_frm=0.
//  - An in-flight frame is discarded wherever it is (loading, full, or unloading); there is no partial output.
//  Input side:
//  - Handshake = s_valid & s_ready at edge.
//  - in_cnt (3b) selects ibuf[in_cnt], then increments.
//  - On the handshake with in_cnt==7: in_full<=1, in_cnt wraps to 0.
//  - s_data is ignored when there is no handshake; s_valid may drop at any time.
//  Transfer:
//  - xfer = in_full & (!out_full | (m_valid & m_ready & m_last)).
//  - On xfer: obuf[k] <= dif_fft.xk[k] (core driven from ibuf); out_full<=1; out_idx<=0; in_full<=0, unless a new 8th sample lands the same edge (not possible, in_cnt restarts at 0).
//  Input ready:
//  - s_ready = !in_full | xfer.
//  - This is a combinational path from m_ready to s_ready, and is permitted.
//  - Sample 0 of the next frame may be written on the xfer edge; the core reads old ibuf contents that cycle.
//  Output side:
//  - m_valid = out_full; m_data = obuf[out_idx]; m_index = out_idx; m_last = (out_idx==7).
//  - m_data is held stable while m_valid & !m_ready.
//  - On handshake: out_idx++. On handshake with m_last: out_full<=0, unless xfer reloads it the same edge.
//  Latency:
//  - 8th input handshake at edge E0 → in_full.
//  - If obuf is free: xfer at E1, then m_valid=1 with X[0] in the cycle after E1.
//  - Minimum: X[0] is first valid 2 edges after x[7] is accepted.
//  - Throughput: 8 samples / 8 clk when the sink never stalls.
//  Backpressure: a stalled sink holds out_full, then in_full stays 1 and s_ready=0 after 8 more samples; no data is lost or overwritten.
//  Framing:
//  - err_frm<=1 if s_last=1 on a handshake with in_cnt!=7, or s_last=0 with in_cnt==7.
//  - Framing is always by count; s_last never resyncs.
//  - Only rst clears err_frm.
//  busy = (in_cnt!=0) | in_full | out_full.
//  Arithmetic: none in ctrl; core scaling and wrap apply unchanged.
// STRUCTURE
//  dif_fft_defs.vh: localparams FFT_N=8, FFT_LOG2N=3, FFT_DW=32, RE_MSB/RE_LSB/IM_MSB/IM_LSB field positions.
//  One sub-module: dif_fft (existing core), instantiated once.
//  Ctrl flags:
//  - in_full and out_full form the state; no separate FSM encoding.
//  - Effective states: LOAD (!in_full), FULL_WAIT (in_full & out_full & no xfer), UNLOAD (out_full).
// TESTING
//  1 Reset: hold rst 2 clk with s_valid=1 → s_ready=1, m_valid=0, busy=0, err_frm=0; no sample counted.
//  2 Impulse:
//    - Stimulus: x0=32'h0100_0000, x1..7=0, s_last on x7, m_ready=1.
//    - Response: 8 outputs all 32'h0100_0000, m_index 0..7, m_last on 7, X[0] valid 2 edges after x7 accepted.
//  3 DC:
//    - Stimulus: all x=32'h0010_0000.
//    - Response: X[0]=32'h0080_0000, X[1..7]=0. Also check random frames against a reference model of the core.
//  4 Back-to-back: 4 frames continuous, m_ready=1 → s_ready never drops after the first frame; 32 outputs in 32 consecutive clk.
//  5 Backpressure:
//    - Stimulus: m_ready=0 for 20 clk after the first m_valid, with input streaming.
//    - Response: m_data stable; s_ready=0 after the 2nd frame's 8th sample; resume yields both frames intact and in order.
//  6 Errors and reset:
//    - s_last on sample 3 → err_frm=1 next cycle and stays; framing is unchanged.
//    - rst mid-unload (out_idx=4) → m_valid=0 next cycle; the next frame outputs from X[0].

Source files
------------

// File: rtl/dif_fft_stream_ctrl_pkg.sv
// Shared types, sizes and complex helpers for the 8-point DIF FFT stream controller and its core.
package dif_fft_stream_ctrl_pkg;

  localparam int unsigned FFT_N     = 8;
  localparam int unsigned FFT_LOG2N = 3;
  localparam int unsigned FFT_DW    = 32;
  localparam int unsigned RE_MSB    = 31;
  localparam int unsigned RE_LSB    = 16;
  localparam int unsigned IM_MSB    = 15;
  localparam int unsigned IM_LSB    = 0;

  localparam logic [FFT_LOG2N-1:0] FFT_LAST = FFT_LOG2N'(FFT_N - 1);

  // cos(pi/4) in Q15
  localparam logic signed [17:0] TW_C = 18'sd23170;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  function automatic cplx_t cadd(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re + b.re;
    r.im = a.im + b.im;
    return r;
  endfunction

  function automatic cplx_t csub(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re - b.re;
    r.im = a.im - b.im;
    return r;
  endfunction

  // Scale by cos(pi/4), floor rounding, wrap to 16 bits
  function automatic logic signed [15:0] mulc(input logic signed [17:0] v);
    logic signed [35:0] p;
    p = 36'(v) * 36'(TW_C);
    return 16'(p >>> 15);
  endfunction

  // Multiply by W8^k, k = 0..3
  function automatic cplx_t twiddle(input cplx_t c, input logic [1:0] k);
    cplx_t r;
    logic signed [17:0] sum;
    logic signed [17:0] dif;
    sum = 18'($signed(c.re)) + 18'($signed(c.im));
    dif = 18'($signed(c.im)) - 18'($signed(c.re));
    r   = c;
    case (k)
      2'd1: begin
        r.re = mulc(sum);
        r.im = mulc(dif);
      end
      2'd2: begin
        r.re = c.im;
        r.im = -c.re;
      end
      2'd3: begin
        r.re = mulc(dif);
        r.im = mulc(-sum);
      end
      default: r = c;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/dif_fft.sv
// Combinational radix-2 decimation-in-frequency 8-point FFT, wrap arithmetic, natural-order output.
module dif_fft
  import dif_fft_stream_ctrl_pkg::*;
(
  input  cplx_t x_i  [FFT_N],
  output cplx_t xk_o [FFT_N]
);

  cplx_t s1 [FFT_N];
  cplx_t s2 [FFT_N];
  cplx_t s3 [FFT_N];

  // Stage 1: span 4, twiddles W8^0..3
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s1[3'(i)]     = cadd(x_i[3'(i)], x_i[3'(i + 4)]);
      s1[3'(i + 4)] = twiddle(csub(x_i[3'(i)], x_i[3'(i + 4)]), 2'(i));
    end
  end

  // Stage 2: span 2, twiddles W8^0 and W8^2
  always_comb begin
    for (int g = 0; g < 8; g += 4) begin
      for (int i = 0; i < 2; i++) begin
        s2[3'(g + i)]     = cadd(s1[3'(g + i)], s1[3'(g + i + 2)]);
        s2[3'(g + i + 2)] = twiddle(csub(s1[3'(g + i)], s1[3'(g + i + 2)]), 2'(2 * i));
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 8; g += 2) begin
      s3[3'(g)]     = cadd(s2[3'(g)], s2[3'(g + 1)]);
      s3[3'(g + 1)] = csub(s2[3'(g)], s2[3'(g + 1)]);
    end
  end

  // DIF leaves bins bit-reversed
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      xk_o[3'(k)] = s3[bitrev3(3'(k))];
    end
  end

endmodule

// File: rtl/dif_fft_stream_ctrl.sv
// Ping/pong streaming sequencer around dif_fft: load 8 samples, transfer through the core, stream bins out.
module dif_fft_stream_ctrl
  import dif_fft_stream_ctrl_pkg::*;
#(
  parameter int unsigned DW = FFT_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW-1:0]        m_data,
  output logic [FFT_LOG2N-1:0] m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err_frm
);

  cplx_t ibuf_q [FFT_N];
  cplx_t ibuf_d [FFT_N];
  cplx_t obuf_q [FFT_N];
  cplx_t obuf_d [FFT_N];
  cplx_t core_xk [FFT_N];

  logic [FFT_LOG2N-1:0] in_cnt_q, in_cnt_d;
  logic [FFT_LOG2N-1:0] out_idx_q, out_idx_d;
  logic                 in_full_q, in_full_d;
  logic                 out_full_q, out_full_d;
  logic                 err_q, err_d;
  logic                 s_hs, m_hs, xfer;

  dif_fft u_core (
    .x_i  (ibuf_q),
    .xk_o (core_xk)
  );

  // Handshakes and port views; s_ready sees m_ready through xfer
  always_comb begin
    m_valid = out_full_q;
    m_index = out_idx_q;
    m_last  = (out_idx_q == FFT_LAST);
    m_data  = DW'(obuf_q[out_idx_q]);
    m_hs    = out_full_q & m_ready;
    xfer    = in_full_q & (~out_full_q | (m_hs & m_last));
    s_ready = ~in_full_q | xfer;
    s_hs    = s_valid & s_ready;
    busy    = (in_cnt_q != '0) | in_full_q | out_full_q;
    err_frm = err_q;
  end

  always_comb begin
    in_cnt_d   = in_cnt_q;
    out_idx_d  = out_idx_q;
    in_full_d  = in_full_q;
    out_full_d = out_full_q;
    err_d      = err_q;
    ibuf_d     = ibuf_q;
    obuf_d     = obuf_q;

    if (s_hs) begin
      ibuf_d[in_cnt_q] = cplx_t'(FFT_DW'(s_data));
      in_cnt_d         = in_cnt_q + 3'd1;
      if (s_last != (in_cnt_q == FFT_LAST)) err_d = 1'b1;
    end

    if (m_hs) begin
      out_idx_d = out_idx_q + 3'd1;
      if (m_last) out_full_d = 1'b0;
    end

    // Core reads the previous ibuf contents even if sample 0 lands this edge
    if (xfer) begin
      obuf_d     = core_xk;
      out_full_d = 1'b1;
      out_idx_d  = '0;
      in_full_d  = 1'b0;
    end

    if (s_hs && (in_cnt_q == FFT_LAST)) in_full_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q   <= '0;
      out_idx_q  <= '0;
      in_full_q  <= 1'b0;
      out_full_q <= 1'b0;
      err_q      <= 1'b0;
      ibuf_q     <= '{default: '0};
      obuf_q     <= '{default: '0};
    end else begin
      in_cnt_q   <= in_cnt_d;
      out_idx_q  <= out_idx_d;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
      err_q      <= err_d;
      ibuf_q     <= ibuf_d;
      obuf_q     <= obuf_d;
    end
  end

endmodule

// File: tb/tb_dif_fft_stream_ctrl.sv
// Randomized bench for dif_fft_stream_ctrl against a frame-level queue model and a loop-form FFT reference.
module tb_dif_fft_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [2:0]  m_index;
  logic        m_last;
  logic        busy;
  logic        err_frm;

  dif_fft_stream_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_index (m_index),
    .m_last  (m_last),
    .busy    (busy),
    .err_frm (err_frm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; logic last; } in_t;
  typedef struct { logic [31:0] data; logic [2:0] idx; } exp_t;

  in_t         inq [$];
  exp_t        exp_q [$];
  logic [31:0] out_log [$];
  logic [31:0] frame [8];
  int          m_cnt = 0;
  logic        m_err = 1'b0;
  logic        fresh = 1'b0;
  int          e_x7 = 0;
  int          e_first_out = -1;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- FFT reference: plain integer arithmetic ----------------
  function automatic int w16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  function automatic int mul707(input int v);
    return w16((v * 23170) >>> 15);
  endfunction

  function automatic void ref_fft(input logic [31:0] x [8], output logic [31:0] xo [8]);
    int re [8];
    int im [8];
    int ar, ai, br, bi, dr, di, tw, rev;
    for (int n = 0; n < 8; n++) begin
      re[n] = w16(int'(x[n][31:16]));
      im[n] = w16(int'(x[n][15:0]));
    end
    for (int span = 4; span >= 1; span = span / 2) begin
      for (int g = 0; g < 8; g += 2 * span) begin
        for (int i = 0; i < span; i++) begin
          ar = re[g + i];        ai = im[g + i];
          br = re[g + i + span]; bi = im[g + i + span];
          re[g + i] = w16(ar + br);
          im[g + i] = w16(ai + bi);
          dr = w16(ar - br);
          di = w16(ai - bi);
          tw = i * (8 / (2 * span));
          case (tw)
            1: begin re[g + i + span] = mul707(dr + di);    im[g + i + span] = mul707(di - dr);    end
            2: begin re[g + i + span] = di;                 im[g + i + span] = w16(-dr);           end
            3: begin re[g + i + span] = mul707(di - dr);    im[g + i + span] = mul707(-(dr + di)); end
            default: begin re[g + i + span] = dr;           im[g + i + span] = di;                 end
          endcase
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      rev = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      xo[k] = {16'(re[rev]), 16'(im[rev])};
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    fresh = 1'b0;
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model for the coming edge
  task automatic step(input logic sv, input logic [31:0] sd, input logic sl, input logic mr,
                      input logic r, output logic shs_o);
    logic        mhs;
    int          qb, popped;
    logic        done;
    logic [31:0] xo [8];
    exp_t        e;
    @(negedge clk);
    rst = r; s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
    #1;
    shs_o = 1'b0;
    if (r) begin
      model_reset();
      return;
    end
    check("busy", 32'(busy), 32'(m_cnt != 0 || exp_q.size() != 0));
    check("err_frm", 32'(err_frm), 32'(m_err));
    check("m_valid", 32'(m_valid), 32'(exp_q.size() > 0 && !fresh));
    check("s_ready", 32'(s_ready), 32'(exp_q.size() <= 8 || (exp_q.size() == 9 && mr)));
    if (m_valid && exp_q.size() > 0) begin
      check("m_data", m_data, exp_q[0].data);
      check("m_index", 32'(m_index), 32'(exp_q[0].idx));
      check("m_last", 32'(m_last), 32'(exp_q[0].idx == 3'd7));
    end
    shs_o  = sv & s_ready;
    mhs    = m_valid & mr;
    qb     = exp_q.size();
    popped = 0;
    done   = 1'b0;
    if (mhs && exp_q.size() > 0) begin
      out_log.push_back(m_data);
      void'(exp_q.pop_front());
      popped = 1;
      if (e_first_out < 0) e_first_out = cyc + 1;
    end
    if (shs_o) begin
      if (sl != (m_cnt == 7)) m_err = 1'b1;
      frame[m_cnt] = sd;
      m_cnt++;
      if (m_cnt == 8) begin
        ref_fft(frame, xo);
        for (int k = 0; k < 8; k++) begin
          e.data = xo[k];
          e.idx  = 3'(k);
          exp_q.push_back(e);
        end
        m_cnt = 0;
        done  = 1'b1;
        e_x7  = cyc + 1;
      end
    end
    fresh = done && (qb - popped == 0);
  endtask

  task automatic push_frame(input logic [31:0] x [8], input int extra_last);
    in_t it;
    for (int i = 0; i < 8; i++) begin
      it.data = x[i];
      it.last = (i == 7) || (i == extra_last);
      inq.push_back(it);
    end
  endtask

  task automatic push_random_frames(input int nf);
    logic [31:0] x [8];
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < 8; i++) x[i] = $urandom;
      push_frame(x, -1);
    end
  endtask

  task automatic run(input int p_v, input int p_r, input int max_cyc);
    int          n;
    logic        sv, mr, hs;
    logic [31:0] sd;
    logic        sl;
    n = 0;
    while ((inq.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
      sv = (inq.size() > 0) && ($urandom_range(99) < 32'(p_v));
      sd = sv ? inq[0].data : $urandom;
      sl = sv ? inq[0].last : 1'($urandom);
      mr = $urandom_range(99) < 32'(p_r);
      step(sv, sd, sl, mr, 1'b0, hs);
      if (hs) void'(inq.pop_front());
      n++;
    end
    check("drain", 32'(inq.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hs, sv, mr;
    logic [31:0] x [8];
    int          first, last, outs, drops, acc, low, stall, n;
    logic        seen;

    // 1: reset held with s_valid high
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, hs);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, hs);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, hs);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_index", 32'(m_index), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_frm), 32'd0);

    // 2: impulse
    out_log.delete();
    e_first_out = -1;
    for (int i = 0; i < 8; i++) x[i] = (i == 0) ? 32'h0100_0000 : 32'h0;
    push_frame(x, -1);
    run(100, 100, 100);
    check("imp_latency", 32'(e_first_out - e_x7), 32'd2);
    check("imp_count", 32'(out_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < out_log.size(); k++) check("imp_bin", out_log[k], 32'h0100_0000);

    // 3: DC, then random frames with random gaps
    out_log.delete();
    for (int i = 0; i < 8; i++) x[i] = 32'h0010_0000;
    push_frame(x, -1);
    run(100, 100, 100);
    check("dc_count", 32'(out_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < out_log.size(); k++)
      check("dc_bin", out_log[k], (k == 0) ? 32'h0080_0000 : 32'h0);
    push_random_frames(6);
    run(60, 60, 1000);

    // 4: four frames back-to-back with an always-ready sink
    push_random_frames(4);
    first = -1; last = -1; outs = 0; drops = 0; acc = 0; n = 0;
    while ((inq.size() > 0 || exp_q.size() > 0) && n < 200) begin
      sv = inq.size() > 0;
      step(sv, sv ? inq[0].data : 32'h0, sv ? inq[0].last : 1'b0, 1'b1, 1'b0, hs);
      if (sv && !s_ready && acc >= 8) drops++;
      if (m_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        outs++;
      end
      if (hs) begin
        void'(inq.pop_front());
        acc++;
      end
      n++;
    end
    check("b2b_sready_drops", 32'(drops), 32'd0);
    check("b2b_outs", 32'(outs), 32'd32);
    check("b2b_span", 32'(last - first), 32'd31);

    // 5: sink stalls 20 clk from the first m_valid while input keeps streaming
    push_random_frames(2);
    seen = 1'b0; stall = 0; low = 0; n = 0;
    while ((inq.size() > 0 || exp_q.size() > 0) && n < 300) begin
      sv = inq.size() > 0;
      mr = seen && (stall >= 20);
      step(sv, sv ? inq[0].data : 32'h0, sv ? inq[0].last : 1'b0, mr, 1'b0, hs);
      if (hs) void'(inq.pop_front());
      if (m_valid) seen = 1'b1;
      if (seen && !mr) stall++;
      if (!s_ready && exp_q.size() == 16) low++;
      n++;
    end
    check("bp_sready_low_seen", 32'(low > 0), 32'd1);
    check("bp_drain", 32'(exp_q.size()), 32'd0);

    // 6: misplaced s_last, then reset mid-unload
    for (int i = 0; i < 8; i++) x[i] = $urandom;
    push_frame(x, 3);
    run(100, 100, 100);
    check("err_sticky", 32'(err_frm), 32'd1);
    push_random_frames(1);
    run(70, 70, 200);
    check("err_kept", 32'(err_frm), 32'd1);

    push_random_frames(1);
    out_log.delete();
    n = 0;
    while (out_log.size() < 4 && n < 100) begin
      sv = inq.size() > 0;
      step(sv, sv ? inq[0].data : 32'h0, sv ? inq[0].last : 1'b0, 1'b1, 1'b0, hs);
      if (hs) void'(inq.pop_front());
      n++;
    end
    check("mid_unload_reached", 32'(out_log.size()), 32'd4);
    inq.delete();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, hs);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, hs);
    check("rst2_m_valid", 32'(m_valid), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_err", 32'(err_frm), 32'd0);
    out_log.delete();
    push_random_frames(2);
    run(80, 80, 300);
    check("rst2_outputs", 32'(out_log.size()), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
